// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and its
// round-robin grant logic.
package dmem_arb_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP, ARB_DONE} arb_state_t;

   localparam int NUM_REQ  = 2;
   localparam int PORT_CPU = 0;
   localparam int PORT_AUX = 1;

   function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic idx);
      logic [NUM_REQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin grant: on contention the port that
// did not win last time is chosen.
module rr_arbiter_2
   import dmem_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               last_grant_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic               gnt_idx_o
);

   always_comb begin
      gnt_idx_o = 1'b0;
      if (req_i[PORT_CPU] && req_i[PORT_AUX]) begin
         gnt_idx_o = ~last_grant_i;
      end else if (req_i[PORT_AUX]) begin
         gnt_idx_o = 1'b1;
      end
      gnt_o = '0;
      if (|req_i) begin
         gnt_o[gnt_idx_o] = 1'b1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU and an aux master.
// One access every four cycles: IDLE (arbitrate), ACCESS, RESP, DONE.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int MEM_DEPTH = 16384
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_REQ-1:0]        m_valid_i,
   input  logic [NUM_REQ-1:0]        m_wen_i,
   input  logic [NUM_REQ-1:0][31:0]  m_addr_i,
   input  logic [NUM_REQ-1:0][31:0]  m_wdata_i,
   input  logic [NUM_REQ-1:0][3:0]   m_strb_i,
   output logic [31:0]               m_rdata_o,
   output logic [NUM_REQ-1:0]        m_done_o,
   output logic [NUM_REQ-1:0]        m_err_o,
   output logic [31:0]               dmem_addr_o,
   output logic                      dmem_en_o,
   output logic                      dmem_wen_o,
   output logic [31:0]               dmem_wdata_o,
   output logic [3:0]                dmem_wstrb_o,
   input  logic [31:0]               dmem_rdata_i
);

   localparam logic [32:0] ADDR_LIMIT = 33'(MEM_DEPTH) * 33'd4;

   arb_state_t          state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic                wen_q, wen_d;
   logic                oor_q, oor_d;
   logic [31:0]         addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [3:0]          strb_q, strb_d;
   logic                en_q, en_d;
   logic                dwen_q, dwen_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [NUM_REQ-1:0]  done_q, done_d;
   logic [NUM_REQ-1:0]  err_q, err_d;

   logic [NUM_REQ-1:0]  gnt;
   logic                gnt_idx;
   logic                req_oor;

   rr_arbiter_2 u_rr (
      .req_i        (m_valid_i),
      .last_grant_i (last_grant_q),
      .gnt_o        (gnt),
      .gnt_idx_o    (gnt_idx)
   );

   assign req_oor = {1'b0, m_addr_i[gnt_idx]} >= ADDR_LIMIT;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE:   if (|gnt) state_d = ARB_ACCESS;
         ARB_ACCESS: state_d = ARB_RESP;
         ARB_RESP:   state_d = ARB_DONE;
         ARB_DONE:   state_d = ARB_IDLE;
         default:    state_d = ARB_IDLE;
      endcase
   end

   // last_grant doubles as the index of the transaction in flight.
   always_comb begin
      last_grant_d = last_grant_q;
      wen_d        = wen_q;
      oor_d        = oor_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      strb_d       = strb_q;
      rdata_d      = rdata_q;
      en_d         = 1'b0;
      dwen_d       = 1'b0;
      done_d       = '0;
      err_d        = '0;
      case (state_q)
         ARB_IDLE: begin
            if (|gnt) begin
               last_grant_d = gnt_idx;
               wen_d        = m_wen_i[gnt_idx];
               oor_d        = req_oor;
               addr_d       = m_addr_i[gnt_idx];
               wdata_d      = m_wdata_i[gnt_idx];
               strb_d       = m_strb_i[gnt_idx];
               en_d         = ~req_oor;
               dwen_d       = m_wen_i[gnt_idx] & ~req_oor;
            end
         end
         ARB_RESP: begin
            rdata_d = (wen_q || oor_q) ? 32'h0 : dmem_rdata_i;
            done_d  = idx_to_onehot(last_grant_q);
            err_d   = oor_q ? idx_to_onehot(last_grant_q) : '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_grant_q <= 1'b1;
         wen_q        <= 1'b0;
         oor_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         strb_q       <= '0;
         en_q         <= 1'b0;
         dwen_q       <= 1'b0;
         rdata_q      <= '0;
         done_q       <= '0;
         err_q        <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         wen_q        <= wen_d;
         oor_q        <= oor_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         strb_q       <= strb_d;
         en_q         <= en_d;
         dwen_q       <= dwen_d;
         rdata_q      <= rdata_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign m_rdata_o    = rdata_q;
   assign m_done_o     = done_q;
   assign m_err_o      = err_q;
   assign dmem_addr_o  = addr_q;
   assign dmem_en_o    = en_q;
   assign dmem_wen_o   = dwen_q;
   assign dmem_wdata_o = wdata_q;
   assign dmem_wstrb_o = strb_q;

   // A requester must hold valid until its done pulse.
   a_valid_held: assert property (@(posedge clk_i) disable iff (rst_i)
      (state_q != ARB_IDLE) |-> m_valid_i[last_grant_q]);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cycle-accurate cases followed by random
// two-port traffic scored against a word-level memory model.
module tb_dmem_arbiter;

   localparam int          MEM_DEPTH = 16384;
   localparam logic [31:0] LIMIT     = 32'(MEM_DEPTH * 4);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        pv [2];
   logic        pw [2];
   logic [31:0] pa [2];
   logic [31:0] pd [2];
   logic [3:0]  ps [2];

   logic [1:0]       m_valid, m_wen, m_done, m_err;
   logic [1:0][31:0] m_addr, m_wdata;
   logic [1:0][3:0]  m_strb;
   logic [31:0]      m_rdata, dmem_addr, dmem_wdata;
   logic             dmem_en, dmem_wen;
   logic [3:0]       dmem_wstrb;
   logic [31:0]      ram_rdata = 32'h0;

   assign m_valid = {pv[1], pv[0]};
   assign m_wen   = {pw[1], pw[0]};
   assign m_addr  = {pa[1], pa[0]};
   assign m_wdata = {pd[1], pd[0]};
   assign m_strb  = {ps[1], ps[0]};

   dmem_arbiter #(.MEM_DEPTH(MEM_DEPTH)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .m_valid_i    (m_valid),
      .m_wen_i      (m_wen),
      .m_addr_i     (m_addr),
      .m_wdata_i    (m_wdata),
      .m_strb_i     (m_strb),
      .m_rdata_o    (m_rdata),
      .m_done_o     (m_done),
      .m_err_o      (m_err),
      .dmem_addr_o  (dmem_addr),
      .dmem_en_o    (dmem_en),
      .dmem_wen_o   (dmem_wen),
      .dmem_wdata_o (dmem_wdata),
      .dmem_wstrb_o (dmem_wstrb),
      .dmem_rdata_i (ram_rdata)
   );

   // Behavioural RAM: synchronous read, byte-strobed write.
   logic [31:0] ram [MEM_DEPTH] = '{default: 32'h0};
   always @(posedge clk) begin
      if (dmem_en) begin
         if (dmem_wen) begin
            for (int b = 0; b < 4; b++) begin
               if (dmem_wstrb[b]) ram[dmem_addr[15:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
            end
         end
         ram_rdata <= ram[dmem_addr[15:2]];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference memory: only words ever written are present, others read 0.
   logic [31:0] ref_mem [int unsigned];

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      int unsigned k = int'(a[15:2]);
      return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
   endfunction

   function automatic void ref_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] w = ref_rd(a);
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      ref_mem[int'(a[15:2])] = w;
   endfunction

   task automatic set_port(input int p, input logic v, input logic wn, input logic [31:0] ad,
                           input logic [31:0] wd, input logic [3:0] st);
      pv[p] = v; pw[p] = wn; pa[p] = ad; pd[p] = wd; ps[p] = st;
   endtask

   // One isolated transaction, checked cycle by cycle from the sampling cycle.
   task automatic single(input int p, input logic wn, input logic [31:0] ad, input logic [31:0] wd,
                         input logic [3:0] st, input logic [31:0] exp_rd, input logic exp_err);
      logic [1:0] oh;
      oh = 2'b01 << p;
      @(posedge clk); #1;
      set_port(p, 1'b1, wn, ad, wd, st);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("en", dmem_en, (c == 1) && !exp_err);
         chk("wen", dmem_wen, (c == 1) && wn && !exp_err);
         chk("done", m_done, (c == 3) ? oh : 2'b00);
         if (c == 1 && !exp_err) begin
            chk("addr", dmem_addr, ad);
            if (wn) begin
               chk("wdata", dmem_wdata, wd);
               chk("wstrb", dmem_wstrb, st);
            end
         end
         if (c == 3) begin
            chk("err", m_err, exp_err ? oh : 2'b00);
            chk("rdata", m_rdata, exp_rd);
         end
      end
      if (wn && !exp_err) ref_wr(ad, wd, st);
      @(posedge clk); #1;
      pv[p] = 1'b0;
   endtask

   int   req_cnt [2] = '{0, 0};
   int   done_cnt[2] = '{0, 0};
   int   passes  [2] = '{0, 0};
   logic fin     [2] = '{1'b0, 1'b0};

   function automatic logic [31:0] pick_addr();
      case ($urandom_range(0, 9))
         0:       return LIMIT + (32'($urandom_range(0, 255)) << 2);
         1:       return LIMIT - 32'd4;
         2:       return $urandom | 32'h8000_0000;
         default: return (32'($urandom_range(0, 31)) << 2) + 32'($urandom_range(0, 3));
      endcase
   endfunction

   task automatic rand_drive(input int p, input int n);
      logic got;
      int   k;
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         set_port(p, 1'b1, 1'($urandom_range(0, 1)), pick_addr(), $urandom, 4'($urandom_range(0, 15)));
         req_cnt[p] = req_cnt[p] + 1;
         got = 1'b0;
         for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            got = m_done[p];
         end
         chk("req_done_in_time", got, 1'b1);
         if (!got) begin
            pv[p] = 1'b0;
            break;
         end
         @(posedge clk); #1;
         pv[p] = 1'b0;
         k = $urandom_range(0, 3);
         if (k != 0) begin
            repeat (k) @(posedge clk);
            #1;
         end
      end
      pv[p] = 1'b0;
      fin[p] = 1'b1;
   endtask

   task automatic monitor();
      logic        oor;
      logic [31:0] exp;
      int          c;
      for (c = 0; c < 5000 && !(fin[0] && fin[1]); c++) begin
         @(negedge clk);
         if (m_done != 2'b00) chk("done_onehot", 32'($countones(m_done)), 32'd1);
         if (dmem_en) chk("en_in_range", dmem_addr < LIMIT, 1'b1);
         for (int p = 0; p < 2; p++) begin
            if (m_done[p]) begin
               chk("done_has_req", pv[p], 1'b1);
               oor = pa[p] >= LIMIT;
               exp = (pw[p] || oor) ? 32'h0 : ref_rd(pa[p]);
               chk("rand_rdata", m_rdata, exp);
               chk("rand_err", m_err[p], oor);
               if (pw[p] && !oor) ref_wr(pa[p], pd[p], ps[p]);
               done_cnt[p] = done_cnt[p] + 1;
               chk("fair_wait", passes[p] <= 1, 1'b1);
               passes[p] = 0;
               if (pv[1-p]) passes[1-p] = passes[1-p] + 1;
            end
         end
      end
      chk("rand_budget", c < 5000, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev;
      logic got;
      // Both ports requesting through reset.
      set_port(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
      set_port(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_done", m_done, 2'b00);
      chk("rst_err", m_err, 2'b00);
      chk("rst_en", dmem_en, 1'b0);
      chk("rst_wen", dmem_wen, 1'b0);
      chk("rst_rdata", m_rdata, 32'h0);
      chk("rst_addr", dmem_addr, 32'h0);
      chk("rst_wdata", dmem_wdata, 32'h0);
      chk("rst_wstrb", dmem_wstrb, 4'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      prev = 0;
      for (int t = 0; t < 4; t++) begin
         got = 1'b0;
         for (int c = 0; c < 12 && !got; c++) begin
            @(negedge clk);
            got = |m_done;
         end
         chk("rr_order", m_done, 2'b01 << (t % 2));
         chk("rr_rdata", m_rdata, 32'h0);
         if (t > 0) chk("rr_interval", cyc - prev, 32'd4);
         prev = cyc;
      end
      @(posedge clk); #1;
      pv[0] = 1'b0;
      pv[1] = 1'b0;

      single(1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
      single(0, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
      single(0, 1'b1, 32'h40, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
      single(1, 1'b1, 32'h40, 32'hA5A5_A5A5, 4'b0011, 32'h0, 1'b0);
      single(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h1234_A5A5, 1'b0);
      single(0, 1'b0, 32'h0001_0000, 32'h0, 4'h0, 32'h0, 1'b1);
      single(1, 1'b1, 32'h0001_0000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
      single(0, 1'b0, 32'h0000_FFFC, 32'h0, 4'h0, 32'h0, 1'b0);

      // Reset while the read of 0x100 is in RESP.
      @(posedge clk); #1;
      set_port(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_done", m_done, 2'b00);
      chk("mid_rst_err", m_err, 2'b00);
      chk("mid_rst_en", dmem_en, 1'b0);
      chk("mid_rst_rdata", m_rdata, 32'h0);
      chk("mid_rst_addr", dmem_addr, 32'h0);
      rst = 1'b0;
      for (int c = 1; c < 4; c++) begin
         @(negedge clk);
         chk("reissue_en", dmem_en, c == 1);
         chk("reissue_done", m_done, (c == 3) ? 2'b01 : 2'b00);
      end
      chk("reissue_rdata", m_rdata, 32'hDEAD_BEEF);
      chk("reissue_err", m_err, 2'b00);
      @(posedge clk); #1;
      pv[0] = 1'b0;

      fork
         rand_drive(0, 60);
         rand_drive(1, 60);
         monitor();
      join
      chk("done_count0", done_cnt[0], req_cnt[0]);
      chk("done_count1", done_cnt[1], req_cnt[1]);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
